pitch_ol_select: RTL and testbench

Open-loop pitch search sequencer for the G.729 encoder pitch stage. It runs the lag-maximum correlation unit three times over the lag ranges [80,143], [40,79] and [20,39], and captures each normalized correlation (cor_max) and its lag (p_max). It then applies the G.729 small-lag preference (THRESHPIT) and reports the open-loop pitch lag T_op. The block sits directly upstream of the lag-maximum unit, drives its start/range inputs, and consumes its results.

---
 rtl/pitch_ol_select_if.sv | 35 +++
 rtl/pitch_ol_select.sv | 152 +++++++++++++++
 tb/tb_pitch_ol_select.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pitch_ol_select_if.sv
// Bus between the open-loop pitch sequencer and its environment: lag-maximum
// unit handshake, shared multiplier/subtractor operands, and search control.
interface pitch_ol_select_if;
  logic        start;
  logic [11:0] signal;
  logic [15:0] L_frame;
  logic        lag_start;
  logic [11:0] lag_signal;
  logic [15:0] lag_L_frame;
  logic [15:0] lag_max;
  logic [15:0] lag_min;
  logic        lag_done;
  logic [15:0] cor_max_in;
  logic [15:0] p_max_in;
  logic [15:0] mult_a;
  logic [15:0] mult_b;
  logic [15:0] mult_in;
  logic [15:0] sub_a;
  logic [15:0] sub_b;
  logic [15:0] sub_in;
  logic [15:0] T_op;
  logic        done;

  modport master (
    input  start, signal, L_frame, lag_done, cor_max_in, p_max_in, mult_in, sub_in,
    output lag_start, lag_signal, lag_L_frame, lag_max, lag_min,
           mult_a, mult_b, sub_a, sub_b, T_op, done
  );

  modport slave (
    output start, signal, L_frame, lag_done, cor_max_in, p_max_in, mult_in, sub_in,
    input  lag_start, lag_signal, lag_L_frame, lag_max, lag_min,
           mult_a, mult_b, sub_a, sub_b, T_op, done
  );
endinterface

// File: rtl/pitch_ol_select.sv
// Open-loop pitch sequencer: runs the lag-maximum unit over three lag ranges,
// then applies the small-lag preference to choose T_op.
module pitch_ol_select #(
  parameter logic [15:0] THRESHPIT = 16'd27853,
  parameter logic [15:0] R1_MAX    = 16'd143,
  parameter logic [15:0] R1_MIN    = 16'd80,
  parameter logic [15:0] R2_MAX    = 16'd79,
  parameter logic [15:0] R2_MIN    = 16'd40,
  parameter logic [15:0] R3_MAX    = 16'd39,
  parameter logic [15:0] R3_MIN    = 16'd20
) (
  input logic               clk,
  input logic               reset,
  pitch_ol_select_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, L1S, L1W, L2S, L2W, L3S, L3W, C2, C3, FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] max_reg [3];
  logic [15:0] p_reg   [3];
  logic [15:0] t_op_reg;

  logic        lag_start, done;
  logic [15:0] lag_max, lag_min, mult_a, mult_b, sub_a, sub_b;
  logic [2:0]  cap;
  logic        sel2, ld_top;
  logic        sub_pos;

  // Strictly positive: sign clear and not zero, so a tie keeps the longer lag.
  assign sub_pos = !bus.sub_in[15] && (bus.sub_in != 16'd0);

  always_comb begin
    state_next = state_reg;
    lag_start  = 1'b0;
    lag_max    = 16'd0;
    lag_min    = 16'd0;
    mult_a     = 16'd0;
    mult_b     = 16'd0;
    sub_a      = 16'd0;
    sub_b      = 16'd0;
    done       = 1'b0;
    cap        = 3'b000;
    sel2       = 1'b0;
    ld_top     = 1'b0;
    case (state_reg)
      IDLE: if (bus.start) state_next = L1S;
      L1S: begin
        lag_start  = 1'b1;
        lag_max    = R1_MAX;
        lag_min    = R1_MIN;
        state_next = L1W;
      end
      L1W: begin
        lag_max = R1_MAX;
        lag_min = R1_MIN;
        if (bus.lag_done) begin
          cap[0]     = 1'b1;
          state_next = L2S;
        end
      end
      L2S: begin
        lag_start  = 1'b1;
        lag_max    = R2_MAX;
        lag_min    = R2_MIN;
        state_next = L2W;
      end
      L2W: begin
        lag_max = R2_MAX;
        lag_min = R2_MIN;
        if (bus.lag_done) begin
          cap[1]     = 1'b1;
          state_next = L3S;
        end
      end
      L3S: begin
        lag_start  = 1'b1;
        lag_max    = R3_MAX;
        lag_min    = R3_MIN;
        state_next = L3W;
      end
      L3W: begin
        lag_max = R3_MAX;
        lag_min = R3_MIN;
        if (bus.lag_done) begin
          cap[2]     = 1'b1;
          state_next = C2;
        end
      end
      C2: begin
        mult_a     = max_reg[1];
        mult_b     = THRESHPIT;
        sub_a      = bus.mult_in;
        sub_b      = max_reg[0];
        sel2       = sub_pos;
        state_next = C3;
      end
      C3: begin
        mult_a     = max_reg[2];
        mult_b     = THRESHPIT;
        sub_a      = bus.mult_in;
        sub_b      = max_reg[0];
        ld_top     = 1'b1;
        state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      t_op_reg  <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        max_reg[i] <= 16'd0;
        p_reg[i]   <= 16'd0;
      end
    end else begin
      state_reg <= state_next;
      for (int i = 0; i < 3; i++) begin
        if (cap[i]) begin
          max_reg[i] <= bus.cor_max_in;
          p_reg[i]   <= bus.p_max_in;
        end
      end
      if (sel2) begin
        max_reg[0] <= max_reg[1];
        p_reg[0]   <= p_reg[1];
      end
      if (ld_top) t_op_reg <= sub_pos ? p_reg[2] : p_reg[0];
    end
  end

  assign bus.lag_start   = lag_start;
  assign bus.lag_signal  = bus.signal;
  assign bus.lag_L_frame = bus.L_frame;
  assign bus.lag_max     = lag_max;
  assign bus.lag_min     = lag_min;
  assign bus.mult_a      = mult_a;
  assign bus.mult_b      = mult_b;
  assign bus.sub_a       = sub_a;
  assign bus.sub_b       = sub_b;
  assign bus.T_op        = t_op_reg;
  assign bus.done        = done;

endmodule

// File: tb/tb_pitch_ol_select.sv
// Directed bench for pitch_ol_select: table of lag-unit results with
// hand-computed selections, plus reset and handshake corner sequences.
module tb_pitch_ol_select;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pitch_ol_select_if ifc ();

  pitch_ol_select dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767)       return 16'h7FFF;
    else if (v < -32768) return 16'h8000;
    else                 return v[15:0];
  endfunction

  // Shared arithmetic units modelled as the environment provides them.
  assign ifc.mult_in = sat16((longint'($signed(ifc.mult_a)) * longint'($signed(ifc.mult_b))) >>> 15);
  assign ifc.sub_in  = sat16(longint'($signed(ifc.sub_a)) - longint'($signed(ifc.sub_b)));

  typedef struct {
    int c1, c2, c3;
    int p1, p2, p3;
    int n1, n2, n3;
    int max1c3;
    int top;
    bit hold;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vecs [5];

  function automatic vec_t mk(input int c1, c2, c3, p1, p2, p3, n1, n2, n3,
                              input int max1c3, top, input bit hold);
    vec_t v;
    v.c1 = c1; v.c2 = c2; v.c3 = c3;
    v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.n1 = n1; v.n2 = n2; v.n3 = n3;
    v.max1c3 = max1c3; v.top = top; v.hold = hold;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cor [3];
    int p   [3];
    int n   [3];
    int rmax [3];
    int rmin [3];
    cor = '{v.c1, v.c2, v.c3};
    p   = '{v.p1, v.p2, v.p3};
    n   = '{v.n1, v.n2, v.n3};
    rmax = '{143, 79, 39};
    rmin = '{80, 40, 20};
    ifc.signal  = 12'(12'h100 + idx);
    ifc.L_frame = 16'd80;
    ifc.start   = 1'b1;
    step;
    if (!v.hold) ifc.start = 1'b0;
    check($sformatf("v%0d lag_signal", idx), int'(ifc.lag_signal), 32'h100 + idx);
    check($sformatf("v%0d lag_L_frame", idx), int'(ifc.lag_L_frame), 80);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("v%0d r%0d lag_start", idx, k + 1), int'(ifc.lag_start), 1);
      check($sformatf("v%0d r%0d lag_max", idx, k + 1), int'(ifc.lag_max), rmax[k]);
      check($sformatf("v%0d r%0d lag_min", idx, k + 1), int'(ifc.lag_min), rmin[k]);
      for (int j = 1; j <= n[k]; j++) begin
        step;
        check($sformatf("v%0d r%0d wait%0d lag_start", idx, k + 1, j), int'(ifc.lag_start), 0);
        check($sformatf("v%0d r%0d wait%0d lag_max", idx, k + 1, j), int'(ifc.lag_max), rmax[k]);
        check($sformatf("v%0d r%0d wait%0d lag_min", idx, k + 1, j), int'(ifc.lag_min), rmin[k]);
        if (j == n[k]) begin
          ifc.lag_done   = 1'b1;
          ifc.cor_max_in = cor[k][15:0];
          ifc.p_max_in   = p[k][15:0];
        end
      end
      step;
      ifc.lag_done   = 1'b0;
      ifc.cor_max_in = 16'h7ABC;
      ifc.p_max_in   = 16'd999;
    end
    check($sformatf("v%0d C2 mult_a", idx), int'($signed(ifc.mult_a)), cor[1]);
    check($sformatf("v%0d C2 mult_b", idx), int'(ifc.mult_b), 27853);
    check($sformatf("v%0d C2 sub_b", idx), int'($signed(ifc.sub_b)), cor[0]);
    check($sformatf("v%0d C2 done", idx), int'(ifc.done), 0);
    step;
    check($sformatf("v%0d C3 mult_a", idx), int'($signed(ifc.mult_a)), cor[2]);
    check($sformatf("v%0d C3 sub_b", idx), int'($signed(ifc.sub_b)), v.max1c3);
    step;
    check($sformatf("v%0d FIN done", idx), int'(ifc.done), 1);
    check($sformatf("v%0d FIN T_op", idx), int'(ifc.T_op), v.top);
    step;
    ifc.start = 1'b0;
    check($sformatf("v%0d after done", idx), int'(ifc.done), 0);
    check($sformatf("v%0d after lag_start", idx), int'(ifc.lag_start), 0);
    check($sformatf("v%0d T_op held", idx), int'(ifc.T_op), v.top);
    $display("[TB] vector %0d: T_op=%0d expected %0d", idx, ifc.T_op, v.top);
  endtask

  initial begin
    //            c1      c2     c3     p1   p2  p3  n1 n2 n3 max1c3  top  hold
    vecs[0] = mk( 10000, 12000, 11000, 120, 60, 30, 3, 5, 2, 12000,  60, 1'b0);
    vecs[1] = mk( 10200, 12000,     0, 120, 60, 30, 1, 1, 1, 10200, 120, 1'b1);
    vecs[2] = mk(  5000,  4000, 20000, 130, 50, 25, 4, 2, 3,  5000,  25, 1'b0);
    vecs[3] = mk(    -5,     0,-32768, 100, 45, 22, 2, 3, 1,     0,  45, 1'b0);
    vecs[4] = mk( 10000, 12000, 11000, 120, 60, 30, 2, 2, 2, 12000,  60, 1'b0);

    reset          = 1'b0;
    ifc.start      = 1'b0;
    ifc.signal     = 12'd0;
    ifc.L_frame    = 16'd0;
    ifc.lag_done   = 1'b0;
    ifc.cor_max_in = 16'd0;
    ifc.p_max_in   = 16'd0;
    step;
    step;
    check("reset T_op", int'(ifc.T_op), 0);
    check("reset done", int'(ifc.done), 0);
    check("reset lag_start", int'(ifc.lag_start), 0);
    check("reset lag_max", int'(ifc.lag_max), 0);
    check("reset lag_min", int'(ifc.lag_min), 0);
    check("reset mult_b", int'(ifc.mult_b), 0);
    reset = 1'b1;
    step;

    // Spurious lag_done while idle must not start anything.
    ifc.lag_done   = 1'b1;
    ifc.cor_max_in = 16'd30000;
    ifc.p_max_in   = 16'd99;
    step;
    ifc.lag_done = 1'b0;
    check("idle lag_done lag_start", int'(ifc.lag_start), 0);
    check("idle lag_done done", int'(ifc.done), 0);
    step;
    check("idle lag_done still idle", int'(ifc.lag_max), 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Reset during range-2 wait.
    ifc.start = 1'b1;
    step;
    ifc.start = 1'b0;
    step;
    ifc.lag_done   = 1'b1;
    ifc.cor_max_in = 16'd7000;
    ifc.p_max_in   = 16'd90;
    step;
    ifc.lag_done = 1'b0;
    step;
    check("pre-reset in L2W lag_max", int'(ifc.lag_max), 79);
    #2 reset = 1'b0;
    #1;
    check("mid reset T_op", int'(ifc.T_op), 0);
    check("mid reset done", int'(ifc.done), 0);
    check("mid reset lag_start", int'(ifc.lag_start), 0);
    check("mid reset lag_max", int'(ifc.lag_max), 0);
    check("mid reset lag_min", int'(ifc.lag_min), 0);
    $display("[TB] reset mid-search: T_op=%0d lag_max=%0d", ifc.T_op, ifc.lag_max);
    @(negedge clk);
    reset = 1'b1;
    step;
    run_vec(vecs[4], 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
